// File: rtl/terminal_ni_pkg.sv
// Shared flit layout and TX state encoding for the terminal network interface.
// Field helpers stand in for the buffer-word slice macros of the router.
package terminal_ni_pkg;
  localparam int ROUTER_W = 14;
  localparam int NUM_VC   = 4;
  localparam int VC_W     = 2;
  localparam int BUF_W    = 22;

  localparam int F_TAIL = 14;
  localparam int F_HEAD = 15;
  localparam int F_VC   = 17;
  localparam int F_FULL = 21;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  function automatic logic [BUF_W-1:0] mk_flit(input logic [ROUTER_W-1:0] dst,
                                               input logic [VC_W-1:0] vc,
                                               input logic head, input logic tail);
    logic [BUF_W-1:0] f;
    f = '0;
    f[ROUTER_W-1:0] = dst;
    f[F_TAIL] = tail;
    f[F_HEAD] = head;
    f[F_VC +: VC_W] = vc;
    f[F_FULL] = 1'b1;
    return f;
  endfunction

  function automatic logic flit_full(input logic [BUF_W-1:0] f);
    return f[F_FULL];
  endfunction
  function automatic logic flit_head(input logic [BUF_W-1:0] f);
    return f[F_HEAD];
  endfunction
  function automatic logic flit_tail(input logic [BUF_W-1:0] f);
    return f[F_TAIL];
  endfunction
  function automatic logic [VC_W-1:0] flit_vc(input logic [BUF_W-1:0] f);
    return f[F_VC +: VC_W];
  endfunction
  function automatic logic [ROUTER_W-1:0] flit_dst(input logic [BUF_W-1:0] f);
    return f[ROUTER_W-1:0];
  endfunction
endpackage

// File: rtl/terminal_ni_if.sv
// Request, injection and ejection signals between the NI and its environment.
interface terminal_ni_if #(parameter int LEN_W = 8);
  import terminal_ni_pkg::*;
  logic                req_valid;
  logic                req_ready;
  logic [ROUTER_W-1:0] req_dst;
  logic [LEN_W-1:0]    req_len;
  logic [VC_W-1:0]     req_vc;
  logic [NUM_VC-1:0]   can_inject;
  logic                inj_take;
  logic [BUF_W-1:0]    inj_flit;
  logic                ej_sample;
  logic [BUF_W-1:0]    ej_flit;

  modport master (output req_valid, req_dst, req_len, req_vc, can_inject, inj_take,
                         ej_sample, ej_flit,
                  input  req_ready, inj_flit);
  modport slave  (input  req_valid, req_dst, req_len, req_vc, can_inject, inj_take,
                         ej_sample, ej_flit,
                  output req_ready, inj_flit);
endinterface

// File: rtl/ni_req_fifo.sv
// Packet request FIFO; an extra pointer bit separates full from empty.
module ni_req_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         ready,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wp, rp, wp_n, rp_n;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign wp_n    = wp + (AW+1)'(do_push);
  assign rp_n    = rp + (AW+1)'(do_pop);
  assign empty   = (wp == rp);
  assign rdata   = mem[rp[AW-1:0]];

  // ready is the registered !full of the post-update pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      ready <= 1'b1;
    end else begin
      wp    <= wp_n;
      rp    <= rp_n;
      ready <= !((wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/terminal_ni.sv
// Terminal NI: segments queued packet requests into flits for router port 0
// and checks per-VC framing of ejected flits.
module terminal_ni
  import terminal_ni_pkg::*;
#(
  parameter int ID     = 1,
  parameter int MAXVC  = NUM_VC,
  parameter int QDEPTH = 4,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  terminal_ni_if.slave     bus,
  output logic [CNT_W-1:0] rx_flit_cnt,
  output logic [CNT_W-1:0] rx_pkt_cnt,
  output logic             proto_err,
  output logic             idle
);
  localparam int QW = ROUTER_W + LEN_W + VC_W;

  logic [QW-1:0] q_rdata;
  logic          q_empty, pop;

  ni_req_fifo #(.W(QW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid),
    .wdata ({bus.req_dst, bus.req_len, bus.req_vc}),
    .ready (bus.req_ready),
    .pop   (pop),
    .rdata (q_rdata),
    .empty (q_empty)
  );

  tx_state_e           state, state_n;
  logic [ROUTER_W-1:0] cur_dst;
  logic [VC_W-1:0]     cur_vc;
  logic [LEN_W-1:0]    remaining, q_len;
  logic                first, load, consume, last;
  logic [BUF_W-1:0]    flit_q;

  assign q_len = q_rdata[VC_W +: LEN_W];
  assign last  = (remaining == LEN_W'(1));

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    consume = 1'b0;
    case (state)
      TX_IDLE: if (!q_empty) begin
        pop     = 1'b1;
        state_n = TX_SEND;
      end
      TX_SEND: begin
        // can_inject only gates loading; a loaded flit waits for inj_take
        if (!flit_q[F_FULL]) load = bus.can_inject[cur_vc];
        else if (bus.inj_take) begin
          consume = 1'b1;
          if (last) state_n = TX_IDLE;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      cur_dst   <= '0;
      cur_vc    <= '0;
      remaining <= '0;
      first     <= 1'b0;
      flit_q    <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        cur_dst   <= q_rdata[QW-1 -: ROUTER_W];
        cur_vc    <= q_rdata[VC_W-1:0];
        remaining <= (q_len == '0) ? LEN_W'(1) : q_len;
        first     <= 1'b1;
      end
      if (load) flit_q <= mk_flit(cur_dst, cur_vc, first, last);
      if (consume) begin
        flit_q    <= '0;
        remaining <= remaining - LEN_W'(1);
        first     <= 1'b0;
      end
    end
  end

  assign bus.inj_flit = flit_q;
  assign idle = q_empty && (state == TX_IDLE) && !flit_q[F_FULL];

  logic [MAXVC-1:0] in_pkt;
  logic [VC_W-1:0]  ej_vc;
  logic             ej_ok, ej_hd, ej_tl, ej_err;
  logic             unused_ej;

  assign ej_ok  = bus.ej_sample && flit_full(bus.ej_flit);
  assign ej_vc  = flit_vc(bus.ej_flit);
  assign ej_hd  = flit_head(bus.ej_flit);
  assign ej_tl  = flit_tail(bus.ej_flit);
  assign ej_err = (ej_hd && in_pkt[ej_vc]) || (!ej_hd && !in_pkt[ej_vc]) ||
                  (flit_dst(bus.ej_flit) != ROUTER_W'(ID));
  assign unused_ej = ^{bus.ej_flit[F_FULL-1:F_VC+VC_W], bus.ej_flit[16]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_flit_cnt <= '0;
      rx_pkt_cnt  <= '0;
      proto_err   <= 1'b0;
      in_pkt      <= '0;
    end else if (ej_ok) begin
      if (rx_flit_cnt != '1) rx_flit_cnt <= rx_flit_cnt + CNT_W'(1);
      if (ej_tl && rx_pkt_cnt != '1) rx_pkt_cnt <= rx_pkt_cnt + CNT_W'(1);
      if (ej_err) proto_err <= 1'b1;
      // a stray head restarts the packet on that VC
      in_pkt[ej_vc] <= ej_hd ? !ej_tl : (in_pkt[ej_vc] && !ej_tl);
    end
  end
endmodule

// File: tb/tb_terminal_ni.sv
// Scoreboarded bench for terminal_ni: expected flits and RX counter states are
// queued at stimulus time and popped by free-running monitors.
module tb_terminal_ni;
  localparam int ID    = 1;
  localparam int CNT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CNT_W-1:0] rx_flit_cnt, rx_pkt_cnt;
  logic             proto_err, idle;

  terminal_ni_if #(.LEN_W(8)) bus();

  terminal_ni #(.ID(ID), .MAXVC(4), .QDEPTH(4), .LEN_W(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .rx_flit_cnt (rx_flit_cnt),
    .rx_pkt_cnt  (rx_pkt_cnt),
    .proto_err   (proto_err),
    .idle        (idle)
  );

  typedef struct packed {
    logic [CNT_W-1:0] f;
    logic [CNT_W-1:0] p;
    logic             e;
  } rx_exp_t;

  int          total = 0;
  int          bad   = 0;
  logic [21:0] exp_tx[$];
  rx_exp_t     exp_rx[$];
  bit          m_open[4];
  int          m_f, m_p;
  bit          m_err;
  bit          mon_en = 1'b0;
  bit          pend_rx = 1'b0;
  logic [21:0] prev_flit = '0;
  logic [3:0]  prev_ci = 4'hF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [21:0] mkf(input int dst, input int vc, input bit h, input bit t);
    logic [21:0] f;
    f = '0;
    f[13:0]  = dst[13:0];
    f[14]    = t;
    f[15]    = h;
    f[18:17] = vc[1:0];
    f[21]    = 1'b1;
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A packet of n flits: first is head, last is tail, len 0 counts as 1.
  task automatic send_req(input int dst, input int len, input int vc, output bit acc);
    bus.req_valid = 1'b1;
    bus.req_dst   = dst[13:0];
    bus.req_len   = len[7:0];
    bus.req_vc    = vc[1:0];
    acc = bus.req_ready;
    if (acc) begin
      int n;
      n = (len == 0) ? 1 : len;
      for (int i = 0; i < n; i++) exp_tx.push_back(mkf(dst, vc, i == 0, i == n - 1));
    end
    tick;
    bus.req_valid = 1'b0;
  endtask

  function automatic void rx_model(input int dst, input int vc, input bit h, input bit t);
    m_f = (m_f < MAXC) ? m_f + 1 : MAXC;
    if (t) m_p = (m_p < MAXC) ? m_p + 1 : MAXC;
    if (h == m_open[vc]) m_err = 1'b1;
    if (dst != ID) m_err = 1'b1;
    if (h) m_open[vc] = !t;
    else if (t) m_open[vc] = 1'b0;
  endfunction

  task automatic eject(input bit full, input int dst, input int vc, input bit h, input bit t);
    logic [21:0] f;
    rx_exp_t     e;
    f = mkf(dst, vc, h, t);
    f[21] = full;
    bus.ej_sample = 1'b1;
    bus.ej_flit   = f;
    if (full) rx_model(dst, vc, h, t);
    e.f = m_f[CNT_W-1:0];
    e.p = m_p[CNT_W-1:0];
    e.e = m_err;
    exp_rx.push_back(e);
    tick;
    bus.ej_sample = 1'b0;
    bus.ej_flit   = '0;
  endtask

  task automatic drain(input bit alt, input string nm);
    int n;
    n = 0;
    bus.can_inject = 4'hF;
    while (!(idle === 1'b1 && exp_tx.size() == 0) && n < 400) begin
      bus.inj_take = alt ? n[0] : 1'b1;
      tick;
      n++;
    end
    bus.inj_take = 1'b0;
    check({nm, "_drained"}, {63'd0, (idle === 1'b1 && exp_tx.size() == 0)}, 64'd1);
  endtask

  task automatic do_reset;
    tick;
    mon_en = 1'b0;
    rst = 1'b1;
    tick;
    exp_tx.delete();
    exp_rx.delete();
    pend_rx = 1'b0;
    m_f = 0; m_p = 0; m_err = 1'b0;
    for (int v = 0; v < 4; v++) m_open[v] = 1'b0;
    rst = 1'b0;
    tick;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    rx_exp_t     e;
    logic [21:0] ef;
    if (mon_en) begin
      if (pend_rx) begin
        if (exp_rx.size() == 0) check("rx_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_rx.pop_front();
          check("rx_flit_cnt", rx_flit_cnt, e.f);
          check("rx_pkt_cnt", rx_pkt_cnt, e.p);
          check("rx_proto_err", proto_err, e.e);
        end
      end
      pend_rx = bus.ej_sample;
      if (!bus.inj_flit[21]) check("tx_empty_zero", bus.inj_flit, 64'd0);
      else if (!prev_flit[21]) check("tx_load_gate", prev_ci[bus.inj_flit[18:17]], 64'd1);
      if (bus.inj_take && bus.inj_flit[21]) begin
        if (exp_tx.size() == 0) check("tx_unexpected", bus.inj_flit, 64'd0);
        else begin
          ef = exp_tx.pop_front();
          check("tx_flit", bus.inj_flit, ef);
        end
      end
    end
    prev_flit = bus.inj_flit;
    prev_ci   = bus.can_inject;
  end

  initial begin
    bit acc;
    int left[4];
    int vc, dst, len;
    bit h, t;
    bus.req_valid = 1'b0; bus.req_dst = '0; bus.req_len = '0; bus.req_vc = '0;
    bus.can_inject = 4'hF; bus.inj_take = 1'b0;
    bus.ej_sample = 1'b0; bus.ej_flit = '0;
    m_f = 0; m_p = 0; m_err = 1'b0;
    for (int v = 0; v < 4; v++) begin m_open[v] = 1'b0; left[v] = 0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_inj_flit", bus.inj_flit, 64'd0);
    check("rst_req_ready", bus.req_ready, 64'd1);
    check("rst_idle", idle, 64'd1);
    check("rst_flit_cnt", rx_flit_cnt, 64'd0);
    check("rst_pkt_cnt", rx_pkt_cnt, 64'd0);
    check("rst_proto_err", proto_err, 64'd0);
    rst = 1'b0;
    tick;
    mon_en = 1'b1;

    send_req(12, 3, 1, acc);
    check("t1_accept", acc, 64'd1);
    drain(1'b1, "t1");

    send_req(5, 0, 2, acc);
    drain(1'b0, "t2");

    bus.can_inject = 4'b1101;
    send_req(7, 2, 1, acc);
    repeat (5) begin
      tick;
      check("t3_stall", bus.inj_flit, 64'd0);
    end
    bus.can_inject = 4'hF;
    tick;
    check("t3_load", bus.inj_flit, mkf(7, 1, 1'b1, 1'b0));
    drain(1'b0, "t3");

    send_req(3, 2, 0, acc);
    repeat (3) tick;
    for (int i = 0; i < 4; i++) begin
      send_req(20 + i, 1 + i, i, acc);
      check("t4_accept", acc, 64'd1);
    end
    check("t4_full", bus.req_ready, 64'd0);
    send_req(99, 1, 0, acc);
    check("t4_refuse", acc, 64'd0);
    drain(1'b0, "t4");

    repeat (300) begin
      bus.can_inject = 4'($urandom);
      bus.inj_take   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1)
        send_req(int'($urandom_range(0, 16383)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), acc);
      else tick;
    end
    drain(1'b0, "t5");

    send_req(9, 5, 3, acc);
    bus.inj_take = 1'b1;
    for (int i = 0; i < 40 && exp_tx.size() > 3; i++) tick;
    bus.inj_take = 1'b0;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_flit", bus.inj_flit, 64'd0);
    check("mid_rst_idle", idle, 64'd1);
    exp_tx.delete();
    tick;
    rst = 1'b0;
    tick;
    mon_en = 1'b1;
    bus.inj_take = 1'b1;
    repeat (6) tick;
    bus.inj_take = 1'b0;
    check("mid_rst_no_tail", idle, 64'd1);

    eject(1'b1, ID, 0, 1'b1, 1'b0);
    eject(1'b1, ID, 2, 1'b1, 1'b1);
    eject(1'b0, ID, 1, 1'b0, 1'b0);
    eject(1'b1, ID, 0, 1'b0, 1'b0);
    eject(1'b1, ID, 0, 1'b0, 1'b1);
    check("t6_flit_cnt", rx_flit_cnt, 64'd4);
    check("t6_pkt_cnt", rx_pkt_cnt, 64'd2);
    check("t6_proto_err", proto_err, 64'd0);

    // legal interleaved traffic, long enough to saturate the flit counter
    repeat (90) begin
      vc = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) eject(1'b0, ID, vc, 1'b0, 1'b0);
      else begin
        h = (left[vc] == 0);
        if (h) left[vc] = int'($urandom_range(1, 4));
        t = (left[vc] == 1);
        left[vc]--;
        eject(1'b1, ID, vc, h, t);
      end
    end
    check("t7_sat_flit_cnt", rx_flit_cnt, MAXC);
    check("t7_proto_err", proto_err, 64'd0);

    do_reset;
    eject(1'b1, ID, 1, 1'b0, 1'b0);
    check("t8_orphan_body", proto_err, 64'd1);
    eject(1'b1, ID, 0, 1'b1, 1'b1);
    check("t8_sticky", proto_err, 64'd1);
    do_reset;
    check("t8_rst_clear", proto_err, 64'd0);
    dst = ID + 1;
    len = 3;
    eject(1'b1, dst, len, 1'b1, 1'b1);
    check("t8_bad_dst", proto_err, 64'd1);
    repeat (3) tick;
    check("t8_bad_dst_sticky", proto_err, 64'd1);
    if (exp_rx.size() != 0 || exp_tx.size() != 0)
      check("final_queues_empty", 64'(exp_rx.size() + exp_tx.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
